// File: rtl/pipe_control_unit.sv
// Purpose: decode control for ALU/memory/branch ops and sequence LDM/STM into one beat per register.
// Latency: registered outputs, an accepted instruction (or first transfer beat) appears one cycle later.
// Backpressure: ready_in = !busy && !stall; stall freezes all state; flush clears outputs and aborts transfers.
module pipe_control_unit #(
  parameter int NREG = 16,
  parameter int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  output logic            ready_in,
  input  logic            SIn,
  input  logic [3:0]      opcode,
  input  logic [1:0]      mode,
  input  logic [NREG-1:0] reg_list,
  input  logic            stall,
  input  logic            flush,
  output logic            WB_EN,
  output logic            MEM_R_EN,
  output logic            MEM_W_EN,
  output logic            B,
  output logic            S,
  output logic            hasSrc1,
  output logic [3:0]      EXE_CMD,
  output logic            valid_out,
  output logic [RW-1:0]   xfer_reg,
  output logic [RW-1:0]   xfer_off,
  output logic            busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BLOCK = 1'b1
  } state_t;

  // One output micro-op; every field is registered as a unit.
  typedef struct packed {
    logic          vld;
    logic          wb;
    logic          mem_r;
    logic          mem_w;
    logic          br;
    logic          s;
    logic          src1;
    logic [3:0]    cmd;
    logic [RW-1:0] xreg;
    logic [RW-1:0] xoff;
  } ctl_t;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  state_t          state_q, state_d;
  logic [NREG-1:0] list_q, list_d;
  logic            load_q, load_d;
  logic [RW-1:0]   cnt_q, cnt_d;
  ctl_t            ctl_q, ctl_d;
  logic            accept;
  logic [NREG-1:0] rest;

  // Index of the lowest set bit; the transfer order is ascending register number.
  function automatic logic [RW-1:0] lowest_idx(input logic [NREG-1:0] v);
    lowest_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = RW'(i);
    end
  endfunction

  function automatic logic [NREG-1:0] clear_lowest(input logic [NREG-1:0] v);
    clear_lowest = v & (v - {{(NREG-1){1'b0}}, 1'b1});
  endfunction

  function automatic ctl_t alu_ctl(input logic wb, input logic [3:0] cmd, input logic s,
                                   input logic src1);
    alu_ctl      = '0;
    alu_ctl.vld  = 1'b1;
    alu_ctl.wb   = wb;
    alu_ctl.cmd  = cmd;
    alu_ctl.s    = s;
    alu_ctl.src1 = src1;
  endfunction

  // A block-transfer beat: address arithmetic is always an ADD off the base register.
  function automatic ctl_t beat(input logic ld, input logic [RW-1:0] r, input logic [RW-1:0] off);
    beat       = '0;
    beat.vld   = 1'b1;
    beat.wb    = ld;
    beat.mem_r = ld;
    beat.mem_w = !ld;
    beat.cmd   = CMD_ADD;
    beat.src1  = 1'b1;
    beat.xreg  = r;
    beat.xoff  = off;
  endfunction

  // Single-cycle instruction classes (ALU, STR/LDR, branch).
  function automatic ctl_t decode(input logic [1:0] md, input logic [3:0] op, input logic s_in);
    decode     = '0;
    decode.vld = 1'b1;
    case (md)
      2'b00: begin
        case (op)
          4'b1101: decode = alu_ctl(1'b1, CMD_MOV, s_in, 1'b0);
          4'b1111: decode = alu_ctl(1'b1, CMD_MVN, s_in, 1'b0);
          4'b0100: decode = alu_ctl(1'b1, CMD_ADD, s_in, 1'b1);
          4'b0101: decode = alu_ctl(1'b1, CMD_ADC, s_in, 1'b1);
          4'b0010: decode = alu_ctl(1'b1, CMD_SUB, s_in, 1'b1);
          4'b0110: decode = alu_ctl(1'b1, CMD_SBC, s_in, 1'b1);
          4'b0000: decode = alu_ctl(1'b1, CMD_AND, s_in, 1'b1);
          4'b1100: decode = alu_ctl(1'b1, CMD_ORR, s_in, 1'b1);
          4'b0001: decode = alu_ctl(1'b1, CMD_EOR, s_in, 1'b1);
          4'b1010: decode = alu_ctl(1'b0, CMD_SUB, 1'b1, 1'b1);
          4'b1000: decode = alu_ctl(1'b0, CMD_AND, 1'b1, 1'b1);
          default: decode.vld = 1'b1;  // unknown opcode: a valid no-op
        endcase
      end
      2'b01: begin
        decode.cmd  = CMD_ADD;
        decode.src1 = 1'b1;
        if (s_in) begin
          decode.mem_r = 1'b1;
          decode.wb    = 1'b1;
          decode.s     = 1'b1;
        end else begin
          decode.mem_w = 1'b1;
        end
      end
      2'b10:   decode.br = 1'b1;
      default: decode.vld = 1'b0;
    endcase
  endfunction

  assign busy     = (state_q == ST_BLOCK);
  assign ready_in = !busy && !stall;
  assign accept   = valid_in && ready_in;

  // Next-state: flush beats stall beats beat emission beats new acceptance.
  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    load_d  = load_q;
    cnt_d   = cnt_q;
    ctl_d   = ctl_q;
    rest    = '0;
    if (flush) begin
      state_d = ST_IDLE;
      list_d  = '0;
      cnt_d   = '0;
      ctl_d   = '0;
    end else if (stall) begin
      state_d = state_q;
    end else if (state_q == ST_BLOCK) begin
      rest   = clear_lowest(list_q);
      ctl_d  = beat(load_q, lowest_idx(list_q), cnt_q);
      list_d = rest;
      cnt_d  = cnt_q + RW'(1);
      if (rest == '0) begin
        // Last beat leaves BLOCK now so the next instruction is taken right behind it.
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else if (accept) begin
      if (mode == 2'b11) begin
        if (reg_list != '0) begin
          rest   = clear_lowest(reg_list);
          ctl_d  = beat(SIn, lowest_idx(reg_list), '0);
          list_d = rest;
          load_d = SIn;
          if (rest != '0) begin
            state_d = ST_BLOCK;
            cnt_d   = RW'(1);
          end else begin
            cnt_d   = '0;
          end
        end else begin
          ctl_d = '0;  // empty list: nothing to transfer, emit a bubble
        end
      end else begin
        ctl_d = decode(mode, opcode, SIn);
      end
    end else begin
      ctl_d = '0;
    end
  end

  // State, captured transfer context and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      list_q  <= '0;
      load_q  <= 1'b0;
      cnt_q   <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
    end
  end

  assign valid_out = ctl_q.vld;
  assign WB_EN     = ctl_q.wb;
  assign MEM_R_EN  = ctl_q.mem_r;
  assign MEM_W_EN  = ctl_q.mem_w;
  assign B         = ctl_q.br;
  assign S         = ctl_q.s;
  assign hasSrc1   = ctl_q.src1;
  assign EXE_CMD   = ctl_q.cmd;
  assign xfer_reg  = ctl_q.xreg;
  assign xfer_off  = ctl_q.xoff;

endmodule

// File: tb/tb_pipe_control_unit.sv
module tb_pipe_control_unit;
  localparam int NREG = 16;
  localparam int RW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_in, ready_in, SIn, stall, flush;
  logic [3:0]      opcode;
  logic [1:0]      mode;
  logic [NREG-1:0] reg_list;
  logic            WB_EN, MEM_R_EN, MEM_W_EN, B, S, hasSrc1, valid_out, busy;
  logic [3:0]      EXE_CMD;
  logic [RW-1:0]   xfer_reg, xfer_off;

  always #5 clk = ~clk;

  pipe_control_unit #(.NREG(NREG), .RW(RW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in), .SIn(SIn),
    .opcode(opcode), .mode(mode), .reg_list(reg_list), .stall(stall), .flush(flush),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .B(B), .S(S),
    .hasSrc1(hasSrc1), .EXE_CMD(EXE_CMD), .valid_out(valid_out), .xfer_reg(xfer_reg),
    .xfer_off(xfer_off), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending transfer registers kept as a queue of indices.
  logic          m_vld, m_wb, m_mr, m_mw, m_b, m_s, m_src;
  logic [3:0]    m_cmd;
  logic [RW-1:0] m_reg, m_off;
  logic          m_load;
  int            beat_no;
  int            pend[$];

  task automatic set_out(input logic v, input logic wb, input logic mr, input logic mw,
                         input logic b, input logic s, input logic src, input logic [3:0] cmd);
    m_vld = v; m_wb = wb; m_mr = mr; m_mw = mw; m_b = b; m_s = s; m_src = src; m_cmd = cmd;
    m_reg = '0; m_off = '0;
  endtask

  task automatic model_reset();
    pend.delete();
    beat_no = 0;
    m_load  = 1'b0;
    set_out(0, 0, 0, 0, 0, 0, 0, 4'd0);
  endtask

  task automatic model_beat();
    int r;
    r = pend.pop_front();
    set_out(1, m_load, m_load, !m_load, 0, 0, 1, 4'b0010);
    m_reg = r[RW-1:0];
    m_off = beat_no[RW-1:0];
    beat_no++;
  endtask

  task automatic model_edge(input logic v, input logic s_in, input logic [3:0] op,
                            input logic [1:0] md, input logic [NREG-1:0] rl,
                            input logic st, input logic fl);
    if (fl) begin
      pend.delete();
      beat_no = 0;
      set_out(0, 0, 0, 0, 0, 0, 0, 4'd0);
    end else if (st) begin
      // everything holds
    end else if (pend.size() != 0) begin
      model_beat();
    end else if (v) begin
      case (md)
        2'd0: case (op)
          4'b1101: set_out(1, 1, 0, 0, 0, s_in, 0, 4'b0001);
          4'b1111: set_out(1, 1, 0, 0, 0, s_in, 0, 4'b1001);
          4'b0100: set_out(1, 1, 0, 0, 0, s_in, 1, 4'b0010);
          4'b0101: set_out(1, 1, 0, 0, 0, s_in, 1, 4'b0011);
          4'b0010: set_out(1, 1, 0, 0, 0, s_in, 1, 4'b0100);
          4'b0110: set_out(1, 1, 0, 0, 0, s_in, 1, 4'b0101);
          4'b0000: set_out(1, 1, 0, 0, 0, s_in, 1, 4'b0110);
          4'b1100: set_out(1, 1, 0, 0, 0, s_in, 1, 4'b0111);
          4'b0001: set_out(1, 1, 0, 0, 0, s_in, 1, 4'b1000);
          4'b1010: set_out(1, 0, 0, 0, 0, 1, 1, 4'b0100);
          4'b1000: set_out(1, 0, 0, 0, 0, 1, 1, 4'b0110);
          default: set_out(1, 0, 0, 0, 0, 0, 0, 4'd0);
        endcase
        2'd1: if (s_in) set_out(1, 1, 1, 0, 0, 1, 1, 4'b0010);
              else      set_out(1, 0, 0, 1, 0, 0, 1, 4'b0010);
        2'd2: set_out(1, 0, 0, 0, 1, 0, 0, 4'd0);
        default: begin
          for (int i = 0; i < NREG; i++) if (rl[i]) pend.push_back(i);
          if (pend.size() == 0) set_out(0, 0, 0, 0, 0, 0, 0, 4'd0);
          else begin
            m_load  = s_in;
            beat_no = 0;
            model_beat();
          end
        end
      endcase
    end else begin
      set_out(0, 0, 0, 0, 0, 0, 0, 4'd0);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {12'd0, valid_out, WB_EN, MEM_R_EN, MEM_W_EN, B, S, hasSrc1, EXE_CMD,
            xfer_reg, xfer_off, busy};
  endfunction

  function automatic logic [31:0] model_vec();
    return {12'd0, m_vld, m_wb, m_mr, m_mw, m_b, m_s, m_src, m_cmd, m_reg, m_off,
            1'(pend.size() != 0)};
  endfunction

  // Called at a negedge: drive, check ready_in, clock, update model, check outputs.
  task automatic step(input logic v, input logic s_in, input logic [3:0] op, input logic [1:0] md,
                      input logic [NREG-1:0] rl, input logic st, input logic fl);
    valid_in = v; SIn = s_in; opcode = op; mode = md; reg_list = rl; stall = st; flush = fl;
    #1;
    check_eq("ready_in", 32'(ready_in), 32'((pend.size() == 0) && !st));
    @(posedge clk);
    model_edge(v, s_in, op, md, rl, st, fl);
    @(negedge clk);
    check_eq("outs", dut_vec(), model_vec());
  endtask

  task automatic idle(); step(0, 0, 4'd0, 2'd0, '0, 0, 0); endtask

  initial begin
    rst = 1'b0; valid_in = 0; SIn = 0; opcode = 0; mode = 0; reg_list = '0; stall = 0; flush = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_outs", dut_vec(), 32'd0);
    rst = 1'b1;

    // First edge after reset accepts: ADD S=1 then MOV S=0.
    step(1, 1, 4'b0100, 2'd0, '0, 0, 0);
    check_eq("add_fields", {WB_EN, EXE_CMD, S, hasSrc1}, {1'b1, 4'b0010, 1'b1, 1'b1});
    step(1, 0, 4'b1101, 2'd0, '0, 0, 0);
    check_eq("mov_fields", {WB_EN, EXE_CMD, S, hasSrc1}, {1'b1, 4'b0001, 1'b0, 1'b0});

    // LDM 0x8025 with an ADD held on valid_in during the beats (must not be taken).
    step(1, 1, 4'd0, 2'd3, 16'h8025, 0, 0);
    check_eq("ldm_b0", {xfer_reg, xfer_off, busy}, {4'd0, 4'd0, 1'b1});
    step(1, 1, 4'b0100, 2'd0, '0, 0, 0);
    check_eq("ldm_b1", {xfer_reg, xfer_off, busy}, {4'd2, 4'd1, 1'b1});
    step(1, 1, 4'b0100, 2'd0, '0, 0, 0);
    check_eq("ldm_b2", {xfer_reg, xfer_off, busy}, {4'd5, 4'd2, 1'b1});
    step(1, 1, 4'b0100, 2'd0, '0, 0, 0);
    check_eq("ldm_b3", {xfer_reg, xfer_off, busy, MEM_R_EN, WB_EN},
             {4'd15, 4'd3, 1'b0, 1'b1, 1'b1});
    step(1, 1, 4'b1010, 2'd0, '0, 0, 0);
    check_eq("after_ldm_cmp", {valid_out, WB_EN, EXE_CMD, S}, {1'b1, 1'b0, 4'b0100, 1'b1});

    // STM 0x0003 with two stall cycles on beat 0.
    step(1, 0, 4'd0, 2'd3, 16'h0003, 0, 0);
    step(0, 0, 4'd0, 2'd0, '0, 1, 0);
    step(0, 0, 4'd0, 2'd0, '0, 1, 0);
    check_eq("stm_held", {xfer_reg, xfer_off, MEM_W_EN}, {4'd0, 4'd0, 1'b1});
    idle();
    check_eq("stm_b1", {xfer_reg, xfer_off, MEM_W_EN, busy}, {4'd1, 4'd1, 1'b1, 1'b0});

    // STM 0x00F0 flushed after beat 1.
    step(1, 0, 4'd0, 2'd3, 16'h00F0, 0, 0);
    idle();
    check_eq("stm_f_b1", {xfer_reg, xfer_off}, {4'd5, 4'd1});
    step(0, 0, 4'd0, 2'd0, '0, 0, 1);
    check_eq("flush_outs", {dut_vec()[31:1], ready_in}, {31'd0, 1'b1});

    // Empty list is a bubble, then CMP.
    step(1, 1, 4'd0, 2'd3, 16'h0000, 0, 0);
    check_eq("empty_list", {valid_out, busy}, {1'b0, 1'b0});
    step(1, 0, 4'b1010, 2'd0, '0, 0, 0);
    check_eq("cmp_fields", {WB_EN, S, EXE_CMD}, {1'b0, 1'b1, 4'b0100});

    // Asynchronous reset in the middle of an LDM.
    step(1, 1, 4'd0, 2'd3, 16'h8025, 0, 0);
    idle();
    #2 rst = 1'b0;
    #1 check_eq("async_rst", dut_vec(), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      logic [NREG-1:0] rl;
      case ($urandom_range(0, 3))
        0:       rl = '0;
        1:       rl = NREG'(1) << $urandom_range(0, NREG - 1);
        2:       rl = NREG'($urandom) & NREG'($urandom);
        default: rl = NREG'($urandom);
      endcase
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), 2'($urandom), rl,
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 24) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_control_unit.md
PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 Parameter NREG, default 16: architectural register count; block-transfer register-list width; power of 2, at least 2.
REQ-002 Parameter RW, default $clog2(NREG): width of register-index and beat-offset outputs.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 valid_in  input  1  decoded instruction fields valid this cycle.
REQ-006 ready_in  output  1  combinational; = !busy && !stall; instruction accepted when valid_in && ready_in.
REQ-007 SIn  input  1  S bit (ALU class); L bit (memory and block classes, 1 = load).
REQ-008 opcode  input  4  ALU opcode: AND 0000, EOR 0001, SUB 0010, ADD 0100, ADC 0101, SBC 0110, TST 1000, CMP 1010, ORR 1100, MOV 1101, MVN 1111.
REQ-009 mode  input  2  00 ALU, 01 STR/LDR, 10 branch, 11 block transfer (LDM/STM).
REQ-010 reg_list  input  NREG  block-transfer register bitmap.
REQ-011 stall  input  1  freeze outputs and state.
REQ-012 flush  input  1  kill outputs and any block transfer in progress.
REQ-013 WB_EN, MEM_R_EN, MEM_W_EN, B, S, hasSrc1  output  1 each  registered control bits.
REQ-014 EXE_CMD  output  4  registered ALU command.
REQ-015 valid_out  output  1  registered; outputs carry a micro-op.
REQ-016 xfer_reg  output  RW  register index of current block-transfer beat; 0 otherwise.
REQ-017 xfer_off  output  RW  beat number in current block transfer (0-based); 0 otherwise.
REQ-018 busy  output  1  registered; high while state is BLOCK.

Function
REQ-019 Outputs SHALL be registered: accepted instruction appears one cycle after acceptance.
REQ-020 Decode table (WB_EN, EXE_CMD, S, hasSrc1):
- MOV 1,0001,SIn,0; MVN 1,1001,SIn,0
- ADD 1,0010,SIn,1; ADC 1,0011,SIn,1; SUB 1,0100,SIn,1; SBC 1,0101,SIn,1
- AND 1,0110,SIn,1; ORR 1,0111,SIn,1; EOR 1,1000,SIn,1
- CMP 0,0100,1,1; TST 0,0110,1,1
- Unlisted opcode: all zero, valid_out=1.
REQ-021 Mode 01: STR gives MEM_W_EN=1, EXE_CMD=0010, hasSrc1=1; LDR gives MEM_R_EN=1, WB_EN=1, EXE_CMD=0010, S=1, hasSrc1=1.
REQ-022 Mode 10 SHALL give B=1, all other control bits 0.
REQ-023 States: IDLE and BLOCK; reset enters IDLE.
REQ-024 Mode 11 with reg_list non-zero SHALL:
- capture reg_list and SIn;
- enter BLOCK;
- emit one beat per cycle, lowest set bit first.
REQ-025 Each beat SHALL carry:
- LDM: MEM_R_EN=1, WB_EN=1;
- STM: MEM_W_EN=1;
- both: EXE_CMD=0010, hasSrc1=1, S=0, valid_out=1, xfer_reg = bit index, xfer_off = beat count.
REQ-026 Each emitted beat's bit SHALL be cleared from the captured list; BLOCK→IDLE in the cycle the last beat is emitted, so a back-to-back instruction is accepted on the next cycle.
REQ-027 The first beat SHALL be emitted one cycle after acceptance; a list with k bits set occupies k consecutive output cycles when no stall occurs.
REQ-028 Mode 11 with reg_list=0 SHALL produce one cycle of valid_out=0 with all controls 0, and remain in IDLE.
REQ-029 No acceptance (valid_in=0) in IDLE SHALL drive all outputs and valid_out to 0 (bubble).
REQ-030 stall=1 and flush=0 SHALL hold all outputs, state, captured list and beat counter unchanged.
REQ-031 flush=1 SHALL:
- take priority over stall and valid_in;
- clear all outputs to 0 on the next edge;
- return state to IDLE and discard the captured list.
REQ-032 No input SHALL be accepted while in BLOCK (ready_in=0).

Reset
REQ-033 rst=0 SHALL asynchronously clear state to IDLE, clear the captured list and beat counter, and drive every output (except combinational ready_in) to 0.
REQ-034 After rst deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-035 ADD with SIn=1 accepted, then MOV with SIn=0 → next two cycles: {WB_EN=1, EXE_CMD=0010, S=1, hasSrc1=1}, then {WB_EN=1, EXE_CMD=0001, S=0, hasSrc1=0}.
REQ-036 LDM with reg_list=0x8025 (NREG=16) → four beats with xfer_reg 0,2,5,15 and xfer_off 0..3, each MEM_R_EN=1 and WB_EN=1; busy for 3 cycles; next instruction accepted after the last beat.
REQ-037 STM with reg_list=0x0003 and stall asserted on the beat-0 cycle for 2 cycles → beat 0 held for 3 cycles, then beat xfer_reg=1, xfer_off=1, MEM_W_EN=1.
REQ-038 STM with reg_list=0x00F0, flush after beat 1 → outputs 0 next cycle, busy=0, ready_in=1.
REQ-039 Mode 11 with reg_list=0 → one cycle valid_out=0, busy stays 0; CMP next → WB_EN=0, S=1, EXE_CMD=0100.
REQ-040 rst pulsed low mid-LDM (asynchronous to clk) → outputs 0 immediately, IDLE, busy=0.
